// File: rtl/alu_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arbiter_if: command, shared-ALU and response bundle for arbiter  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface alu_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int OPW   = 3
);
   logic             req0_valid;
   logic             req0_ready;
   logic [OPW-1:0]   req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   logic [OPW-1:0]   req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic [WIDTH-1:0] alu_in1;
   logic [WIDTH-1:0] alu_in2;
   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_out;

   logic             rsp_valid;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_ready;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  alu_out, rsp_ready,
      output req0_ready, req1_ready,
      output alu_in1, alu_in2, alu_op,
      output rsp_valid, rsp_id, rsp_data
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output alu_out, rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_in1, alu_in2, alu_op,
      input  rsp_valid, rsp_id, rsp_data
   );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arbiter: round-robin sharing of one combinational ALU by two     |
// | requesters, with id-tagged valid/ready response                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_arbiter #(
   parameter int WIDTH = 16,
   parameter int OPW   = 3
) (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_last;
   logic             r_id;
   logic [WIDTH-1:0] r_in1;
   logic [WIDTH-1:0] r_in2;
   logic [WIDTH-1:0] r_data;
   logic [OPW-1:0]   r_op;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_accept;

   // Grants depend only on state, last and the valids; a grant implies valid.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_gnt0 = bus.req0_valid && (!bus.req1_valid || r_last);
            w_gnt1 = bus.req1_valid && (!bus.req0_valid || !r_last);
            if (w_gnt0 || w_gnt1) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_accept = w_gnt0 | w_gnt1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_id    <= 1'b0;
         r_in1   <= '0;
         r_in2   <= '0;
         r_op    <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_in1  <= w_gnt1 ? bus.req1_a  : bus.req0_a;
            r_in2  <= w_gnt1 ? bus.req1_b  : bus.req0_b;
            r_op   <= w_gnt1 ? bus.req1_op : bus.req0_op;
            r_id   <= w_gnt1;
            r_last <= w_gnt1;
         end
         // Operands have been stable for the whole EXEC cycle here.
         if (r_state == S_EXEC) begin
            r_data <= bus.alu_out;
         end
      end
   end

   assign bus.req0_ready = w_gnt0;
   assign bus.req1_ready = w_gnt1;
   assign bus.alu_in1    = r_in1;
   assign bus.alu_in2    = r_in2;
   assign bus.alu_op     = r_op;
   assign bus.rsp_valid  = (r_state == S_RESP);
   assign bus.rsp_id     = r_id;
   assign bus.rsp_data   = r_data;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_arbiter: directed scoreboard bench with an xnor ALU model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_arbiter;
   localparam int WIDTH = 16;
   localparam int OPW   = 3;

   typedef struct packed {
      logic             id;
      logic [WIDTH-1:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

   alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.alu_out = ~(bus.alu_in1 ^ bus.alu_in2);

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   n_acc  = 0;
   int   n_rsp  = 0;
   logic solo   = 1'b0;
   rsp_t sb_q[$];
   int   gnt_q[$];
   int   acc_cyc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Accept monitor: records grants and pushes expected responses.
   always @(negedge clk) begin
      if (!rst) begin
         check("one_hot_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
         if (solo) check("solo_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
         if (bus.req0_valid && bus.req0_ready) begin
            sb_q.push_back({1'b0, ~(bus.req0_a ^ bus.req0_b)});
            gnt_q.push_back(0);
            acc_cyc.push_back(cyc);
            n_acc++;
         end
         if (bus.req1_valid && bus.req1_ready) begin
            sb_q.push_back({1'b1, ~(bus.req1_a ^ bus.req1_b)});
            gnt_q.push_back(1);
            acc_cyc.push_back(cyc);
            n_acc++;
         end
      end
   end

   // Response monitor: pops and compares on each response handshake.
   always @(negedge clk) begin
      rsp_t e;
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         n_rsp++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got id %0d data %0h expected none", bus.rsp_id, bus.rsp_data);
         end else begin
            e = sb_q.pop_front();
            check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
            check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, e.data});
         end
      end
   end

   task automatic wait_acc(input int target, input int budget, input string name);
      int n = 0;
      while (n_acc < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (n_acc < target) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d accepts expected %0d", name, n_acc, target);
      end
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      check({name, "_drain"}, sb_q.size(), 32'd0);
   endtask

   initial begin
      int base;
      int base_rsp;
      bus.req0_valid = 0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
      bus.rsp_ready  = 0;

      // Asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_id",    {31'd0, bus.rsp_id},    32'd0);
      check("rst_rsp_data",  {16'd0, bus.rsp_data},  32'd0);
      check("rst_alu_in1",   {16'd0, bus.alu_in1},   32'd0);
      check("rst_alu_in2",   {16'd0, bus.alu_in2},   32'd0);
      check("rst_alu_op",    {29'd0, bus.alu_op},    32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("idle_ready0", {31'd0, bus.req0_ready}, 32'd0);
         check("idle_ready1", {31'd0, bus.req1_ready}, 32'd0);
      end

      // Single command, requester 0
      @(posedge clk); #1;
      bus.rsp_ready = 1;
      bus.req0_op = 3'd5; bus.req0_a = 16'hF0F0; bus.req0_b = 16'hFF00; bus.req0_valid = 1;
      base = n_acc;
      wait_acc(base + 1, 10, "single");
      #1 bus.req0_valid = 0;
      check("single_alu_in1", {16'd0, bus.alu_in1}, 32'h0000F0F0);
      check("single_alu_in2", {16'd0, bus.alu_in2}, 32'h0000FF00);
      check("single_alu_op",  {29'd0, bus.alu_op},  32'd5);
      check("single_exec_valid", {31'd0, bus.rsp_valid}, 32'd0);
      @(posedge clk); #1;
      check("single_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("single_rsp_id",    {31'd0, bus.rsp_id},    32'd0);
      check("single_rsp_data",  {16'd0, bus.rsp_data},  32'h0000F00F);
      @(posedge clk); #1;
      check("single_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("single_hold_in1", {16'd0, bus.alu_in1}, 32'h0000F0F0);

      // Backpressure, requester 1, result 16'h1234
      bus.rsp_ready = 0;
      bus.req1_op = 3'd2; bus.req1_a = 16'hEDCB; bus.req1_b = 16'h0000; bus.req1_valid = 1;
      base = n_acc;
      wait_acc(base + 1, 10, "bp");
      #1 bus.req1_valid = 0;
      @(posedge clk); #1;
      bus.req0_op = 3'd1; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_valid = 1;
      base = n_acc;
      repeat (5) begin
         @(negedge clk);
         check("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
         check("bp_rsp_id",    {31'd0, bus.rsp_id},    32'd1);
         check("bp_rsp_data",  {16'd0, bus.rsp_data},  32'h00001234);
         check("bp_ready0",    {31'd0, bus.req0_ready}, 32'd0);
         check("bp_ready1",    {31'd0, bus.req1_ready}, 32'd0);
      end
      check("bp_no_accept", n_acc, base);
      @(posedge clk); #1;
      bus.rsp_ready = 1;
      @(posedge clk); #1;
      check("bp_idle_ready0", {31'd0, bus.req0_ready}, 32'd1);
      check("bp_idle_valid",  {31'd0, bus.rsp_valid},  32'd0);
      bus.req0_valid = 0;
      drain(10, "bp");

      // Reset during EXEC, then contention
      bus.req0_op = 3'd7; bus.req0_a = 16'hAAAA; bus.req0_b = 16'h5555; bus.req0_valid = 1;
      base = n_acc;
      wait_acc(base + 1, 10, "rstop");
      #1 bus.req0_valid = 0;
      #2 rst = 1'b1;
      sb_q.delete();
      base_rsp = n_rsp;
      #1;
      check("rstop_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rstop_alu_in1",   {16'd0, bus.alu_in1},   32'd0);
      @(posedge clk); #1;
      check("rstop_hold_valid", {31'd0, bus.rsp_valid}, 32'd0);
      gnt_q.delete();
      acc_cyc.delete();
      bus.req0_op = 3'd3; bus.req0_a = 16'h0F0F; bus.req0_b = 16'h00FF; bus.req0_valid = 1;
      bus.req1_op = 3'd4; bus.req1_a = 16'h1234; bus.req1_b = 16'h4321; bus.req1_valid = 1;
      base = n_acc;
      rst = 1'b0;
      wait_acc(base + 6, 60, "cont");
      #1;
      bus.req0_valid = 0;
      bus.req1_valid = 0;
      drain(20, "cont");
      check("cont_rsp_count", n_rsp - base_rsp, 32'd6);
      check("cont_gnt_count", gnt_q.size(), 32'd6);
      for (int i = 0; i < gnt_q.size() && i < 6; i++) begin
         check("cont_grant_order", gnt_q[i], i % 2);
         if (i > 0) check("cont_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd3);
      end

      // Solo streaming on requester 1
      solo = 1'b1;
      base = n_acc;
      for (int i = 0; i < 20; i++) begin
         bus.req1_a  = 16'($urandom);
         bus.req1_b  = 16'($urandom);
         bus.req1_op = 3'($urandom_range(0, 7));
         bus.req1_valid = 1;
         wait_acc(base + i + 1, 10, "solo");
         #1;
      end
      bus.req1_valid = 0;
      drain(10, "solo");
      solo = 1'b0;
      check("solo_accepts", n_acc - base, 32'd20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
